// File: rtl/usb_pkg.sv
// Shared USB definitions: transmit-packetizer state encoding and CRC16 constants.
// Used by the CRC appender and by any receive-side CRC checker.
package usb_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_CRC_LO = 2'd2;
   localparam logic [1:0] ST_CRC_HI = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE   = ST_IDLE,
      S_DATA   = ST_DATA,
      S_CRC_LO = ST_CRC_LO,
      S_CRC_HI = ST_CRC_HI
   } usb_tx_state_e;

   // Reflected x^16+x^15+x^2+1, processed LSB-first
   localparam logic [15:0] USB_CRC16_POLY_REFL     = 16'hA001;
   localparam logic [15:0] USB_CRC16_INIT          = 16'hFFFF;
   localparam logic [15:0] USB_CRC16_RESIDUAL_REFL = 16'hB001;

endpackage

// File: rtl/usb_crc16_byte.sv
// Combinational USB CRC16 update: folds one byte, LSB first, into the running CRC.
// Shared by transmit-side append and receive-side check.
module usb_crc16_byte
   import usb_pkg::*;
(
   input  logic [15:0] crc_in,
   input  logic [7:0]  data,
   output logic [15:0] crc_out
);

   always_comb begin
      crc_out = crc_in ^ {8'h00, data};
      for (int i = 0; i < 8; i++) begin
         if (crc_out[0]) crc_out = (crc_out >> 1) ^ USB_CRC16_POLY_REFL;
         else            crc_out = crc_out >> 1;
      end
   end

endmodule

// File: rtl/usb_tx_crc16_append.sv
// Payload packetizer ahead of the USB TX handshake FSM: forwards bytes through a
// one-deep output slot, computes the data CRC16 on the fly and appends it.
module usb_tx_crc16_append
   import usb_pkg::*;
#(
   parameter int MAX_BYTES = 1023,
   parameter int CNT_W     = 10,
   parameter int CRC_EN    = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   input  logic             in_empty,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [7:0]       tx_data,
   output logic [CNT_W-1:0] byte_cnt,
   output logic             pkt_done,
   output logic             len_err
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BYTES);

   usb_tx_state_e    state_q, state_d;
   logic [15:0]      crc_q, crc_d, crc_next;
   logic             tx_valid_q, tx_valid_d;
   logic [7:0]       tx_data_q, tx_data_d;
   logic             tx_last_q, tx_last_d;
   logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
   logic             pkt_done_q, pkt_done_d;
   logic             len_err_q, len_err_d;

   logic slot_free, accept, consume;

   generate
      if (CRC_EN != 0) begin : g_crc
         usb_crc16_byte u_crc (
            .crc_in  (crc_q),
            .data    (in_data),
            .crc_out (crc_next)
         );
      end else begin : g_nocrc
         assign crc_next = crc_q;
      end
   endgenerate

   always_comb begin
      slot_free = !tx_valid_q || tx_ready;
      in_ready  = slot_free && (state_q == S_IDLE || state_q == S_DATA);
      accept    = in_valid && in_ready;
      consume   = tx_valid_q && tx_ready;
   end

   always_comb begin
      state_d    = state_q;
      crc_d      = crc_q;
      tx_valid_d = tx_valid_q && !tx_ready;
      tx_data_d  = tx_data_q;
      tx_last_d  = tx_last_q && !tx_ready;
      byte_cnt_d = byte_cnt_q;
      len_err_d  = len_err_q;
      // Marked byte leaving the slot closes the packet
      pkt_done_d = consume && tx_last_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (in_last && in_empty) begin
                  byte_cnt_d = '0;
                  if (CRC_EN != 0) state_d = S_CRC_LO;
                  else             pkt_done_d = 1'b1;
               end else begin
                  tx_valid_d = 1'b1;
                  tx_data_d  = in_data;
                  tx_last_d  = 1'b0;
                  crc_d      = crc_next;
                  byte_cnt_d = CNT_W'(1);
                  if (in_last) begin
                     if (CRC_EN != 0) begin
                        state_d = S_CRC_LO;
                     end else begin
                        tx_last_d = 1'b1;
                        crc_d     = USB_CRC16_INIT;
                     end
                  end else begin
                     state_d = S_DATA;
                  end
               end
            end
         end

         S_DATA: begin
            if (accept) begin
               tx_valid_d = 1'b1;
               tx_data_d  = in_data;
               tx_last_d  = 1'b0;
               crc_d      = crc_next;
               // Oversized packets are still forwarded; the count just pins
               if (byte_cnt_q == CNT_MAX) len_err_d  = 1'b1;
               else                       byte_cnt_d = byte_cnt_q + CNT_W'(1);
               if (in_last) begin
                  if (CRC_EN != 0) begin
                     state_d = S_CRC_LO;
                  end else begin
                     state_d   = S_IDLE;
                     tx_last_d = 1'b1;
                     crc_d     = USB_CRC16_INIT;
                  end
               end
            end
         end

         S_CRC_LO: begin
            if (slot_free) begin
               tx_valid_d = 1'b1;
               tx_data_d  = ~crc_q[7:0];
               tx_last_d  = 1'b0;
               state_d    = S_CRC_HI;
            end
         end

         S_CRC_HI: begin
            if (slot_free) begin
               tx_valid_d = 1'b1;
               tx_data_d  = ~crc_q[15:8];
               tx_last_d  = 1'b1;
               state_d    = S_IDLE;
               crc_d      = USB_CRC16_INIT;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         crc_q      <= USB_CRC16_INIT;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         tx_last_q  <= 1'b0;
         byte_cnt_q <= '0;
         pkt_done_q <= 1'b0;
         len_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         crc_q      <= crc_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         tx_last_q  <= tx_last_d;
         byte_cnt_q <= byte_cnt_d;
         pkt_done_q <= pkt_done_d;
         len_err_q  <= len_err_d;
      end
   end

   assign tx_valid = tx_valid_q;
   assign tx_data  = tx_data_q;
   assign byte_cnt = byte_cnt_q;
   assign pkt_done = pkt_done_q;
   assign len_err  = len_err_q;

endmodule

// File: tb/tb_usb_tx_crc16_append.sv
// Directed bench for usb_tx_crc16_append: default build, a MAX_BYTES=4 build
// and a CRC_EN=0 build share clock, reset, payload bus and tx_ready.
module tb_usb_tx_crc16_append;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [2:0] in_valid = 3'b000;
   logic [7:0] in_data = 8'h00;
   logic in_last = 1'b0;
   logic in_empty = 1'b0;
   logic tx_ready = 1'b1;
   logic rand_mode = 1'b0;

   logic [2:0] in_ready, tv, pd, le;
   logic [7:0] td0, td1, td2;
   logic [9:0] bc0, bc2;
   logic [2:0] bc1;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   logic [7:0] q0[$], q1[$], q2[$];
   int cy0[$], dc0[$];
   int dn0 = 0, dn1 = 0, dn2 = 0;
   logic pst_stall = 1'b0, pst_rst = 1'b1;
   logic [7:0] pst_data = 8'h00;

   usb_tx_crc16_append dut (
      .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
      .in_data(in_data), .in_last(in_last), .in_empty(in_empty),
      .tx_valid(tv[0]), .tx_ready(tx_ready), .tx_data(td0),
      .byte_cnt(bc0), .pkt_done(pd[0]), .len_err(le[0]));

   usb_tx_crc16_append #(.MAX_BYTES(4), .CNT_W(3), .CRC_EN(1)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
      .in_data(in_data), .in_last(in_last), .in_empty(in_empty),
      .tx_valid(tv[1]), .tx_ready(tx_ready), .tx_data(td1),
      .byte_cnt(bc1), .pkt_done(pd[1]), .len_err(le[1]));

   usb_tx_crc16_append #(.MAX_BYTES(1023), .CNT_W(10), .CRC_EN(0)) dutp (
      .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
      .in_data(in_data), .in_last(in_last), .in_empty(in_empty),
      .tx_valid(tv[2]), .tx_ready(tx_ready), .tx_data(td2),
      .byte_cnt(bc2), .pkt_done(pd[2]), .len_err(le[2]));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      tx_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Collect consumed bytes and pulses; watch slot stability while stalled
   always @(negedge clk) begin
      if (tv[0] && tx_ready) begin q0.push_back(td0); cy0.push_back(cyc); end
      if (tv[1] && tx_ready) q1.push_back(td1);
      if (tv[2] && tx_ready) q2.push_back(td2);
      if (pd[0]) begin dn0++; dc0.push_back(cyc); end
      if (pd[1]) dn1++;
      if (pd[2]) dn2++;
      if (pst_stall && !pst_rst) begin
         checks++;
         if (tv[0] !== 1'b1 || td0 !== pst_data) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b data=%h expected valid=1 data=%h", tv[0], td0, pst_data);
         end
      end
      pst_stall = tv[0] && !tx_ready;
      pst_data  = td0;
      pst_rst   = reset;
   end

   function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] d);
      logic [15:0] r;
      r = c ^ {8'h00, d};
      for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
      return r;
   endfunction

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr();
      q0.delete(); q1.delete(); q2.delete(); cy0.delete(); dc0.delete();
      dn0 = 0; dn1 = 0; dn2 = 0;
   endtask

   task automatic send(input int sel, input logic [7:0] d, input logic last, input logic empty);
      int n;
      n = 0;
      in_data = d; in_last = last; in_empty = empty;
      in_valid[sel] = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready[sel]) break;
         n++;
         if (n > 200) begin
            checks++; errors++;
            $display("FAIL send_timeout: inst=%0d got in_ready=0 expected 1 within 200 cycles", sel);
            break;
         end
      end
      @(posedge clk); #1;
      in_valid[sel] = 1'b0;
   endtask

   task automatic test_reset();
      idle(3);
      @(negedge clk);
      checks++;
      if (tv !== 3'b000 || pd !== 3'b000 || le !== 3'b000) begin
         errors++;
         $display("FAIL reset_flags: got tv=%b pd=%b le=%b expected 000", tv, pd, le);
      end
      checks++;
      if (td0 !== 8'h00 || bc0 !== 10'd0 || bc1 !== 3'd0) begin
         errors++;
         $display("FAIL reset_data: got td=%h bc0=%0d bc1=%0d expected 0", td0, bc0, bc1);
      end
      checks++;
      if (in_ready !== 3'b111) begin
         errors++;
         $display("FAIL reset_ready: got %b expected 111", in_ready);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      idle(1);
   endtask

   task automatic test_check_string();
      logic [7:0] exp_b [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36,
                                 8'h37, 8'h38, 8'h39, 8'hC8, 8'hB4};
      clr();
      for (int i = 0; i < 9; i++) send(0, 8'(8'h31 + i), i == 8, 1'b0);
      idle(6);
      checks++;
      if (q0.size() != 11) begin
         errors++;
         $display("FAIL str_len: got %0d expected 11", q0.size());
      end else begin
         for (int i = 0; i < 11; i++) begin
            checks++;
            if (q0[i] !== exp_b[i]) begin
               errors++;
               $display("FAIL str_byte%0d: got %h expected %h", i, q0[i], exp_b[i]);
            end
         end
         checks++;
         if (dn0 != 1 || dc0.size() != 1 || dc0[0] != cy0[10] + 1) begin
            errors++;
            $display("FAIL str_done: got pulses=%0d expected 1 one cycle after last consume", dn0);
         end
      end
      checks++;
      if (bc0 !== 10'd9) begin
         errors++;
         $display("FAIL str_cnt: got %0d expected 9", bc0);
      end
   endtask

   task automatic test_zero_len();
      clr();
      send(0, 8'h00, 1'b1, 1'b1);
      idle(6);
      checks++;
      if (q0.size() != 2 || q0[0] !== 8'h00 || q0[1] !== 8'h00) begin
         errors++;
         $display("FAIL zlp_bytes: got %0d bytes expected 2 bytes 00 00", q0.size());
      end
      checks++;
      if (bc0 !== 10'd0 || dn0 != 1) begin
         errors++;
         $display("FAIL zlp_cnt_done: got cnt=%0d done=%0d expected 0 and 1", bc0, dn0);
      end
   endtask

   task automatic test_random_stall();
      logic [7:0] pay[$];
      logic [15:0] r;
      int n;
      clr();
      for (int i = 0; i < 64; i++) pay.push_back(8'($urandom_range(0, 255)));
      rand_mode = 1'b1;
      for (int i = 0; i < 64; i++) send(0, pay[i], i == 63, 1'b0);
      n = 0;
      while (q0.size() < 66 && n < 500) begin idle(1); n++; end
      rand_mode = 1'b0;
      idle(4);
      checks++;
      if (q0.size() != 66) begin
         errors++;
         $display("FAIL rnd_len: got %0d expected 66", q0.size());
      end else begin
         for (int i = 0; i < 64; i++) begin
            checks++;
            if (q0[i] !== pay[i]) begin
               errors++;
               $display("FAIL rnd_byte%0d: got %h expected %h", i, q0[i], pay[i]);
            end
         end
         r = 16'hFFFF;
         for (int i = 0; i < 66; i++) r = crc_upd(r, q0[i]);
         checks++;
         if (r !== 16'hB001) begin
            errors++;
            $display("FAIL rnd_residual: got %h expected b001", r);
         end
      end
      checks++;
      if (dn0 != 1) begin
         errors++;
         $display("FAIL rnd_done: got %0d expected 1", dn0);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] ca, cb;
      logic [7:0] exp_b [6];
      ca = ~crc_upd(16'hFFFF, 8'hAA);
      cb = ~crc_upd(16'hFFFF, 8'h55);
      exp_b = '{8'hAA, ca[7:0], ca[15:8], 8'h55, cb[7:0], cb[15:8]};
      clr();
      send(0, 8'hAA, 1'b1, 1'b0);
      send(0, 8'h55, 1'b1, 1'b0);
      idle(6);
      checks++;
      if (q0.size() != 6) begin
         errors++;
         $display("FAIL b2b_len: got %0d expected 6", q0.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            checks++;
            if (q0[i] !== exp_b[i]) begin
               errors++;
               $display("FAIL b2b_byte%0d: got %h expected %h", i, q0[i], exp_b[i]);
            end
         end
         checks++;
         if (cy0[5] - cy0[0] != 5) begin
            errors++;
            $display("FAIL b2b_gap: got span=%0d cycles expected 5", cy0[5] - cy0[0]);
         end
      end
      checks++;
      if (dn0 != 2) begin
         errors++;
         $display("FAIL b2b_done: got %0d expected 2", dn0);
      end
   endtask

   task automatic test_reset_mid();
      logic [15:0] c;
      clr();
      for (int i = 0; i < 4; i++) send(0, 8'(8'h10 + i), 1'b0, 1'b0);
      in_data = 8'h14; in_last = 1'b0; in_valid[0] = 1'b1; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; in_valid[0] = 1'b0;
      @(negedge clk);
      checks++;
      if (tv[0] !== 1'b0 || bc0 !== 10'd0) begin
         errors++;
         $display("FAIL rst_mid_state: got tv=%b cnt=%0d expected 0 0", tv[0], bc0);
      end
      idle(5);
      checks++;
      if (q0.size() != 4 || dn0 != 0) begin
         errors++;
         $display("FAIL rst_mid_drop: got %0d bytes done=%0d expected 4 bytes done=0", q0.size(), dn0);
      end
      clr();
      c = 16'hFFFF;
      for (int i = 0; i < 4; i++) begin
         send(0, 8'(i), i == 3, 1'b0);
         c = crc_upd(c, 8'(i));
      end
      c = ~c;
      idle(6);
      checks++;
      if (q0.size() != 6 || q0[4] !== c[7:0] || q0[5] !== c[15:8]) begin
         errors++;
         $display("FAIL rst_mid_crc: got %0d bytes expected 6 ending %h %h", q0.size(), c[7:0], c[15:8]);
      end
   endtask

   task automatic test_len_err();
      logic [15:0] c;
      clr();
      c = 16'hFFFF;
      for (int i = 0; i < 6; i++) begin
         send(1, 8'(i + 1), i == 5, 1'b0);
         c = crc_upd(c, 8'(i + 1));
         if (i == 3) begin
            checks++;
            if (le[1] !== 1'b0 || bc1 !== 3'd4) begin
               errors++;
               $display("FAIL len_at4: got le=%b cnt=%0d expected 0 4", le[1], bc1);
            end
         end
         if (i == 4) begin
            checks++;
            if (le[1] !== 1'b1 || bc1 !== 3'd4) begin
               errors++;
               $display("FAIL len_at5: got le=%b cnt=%0d expected 1 4", le[1], bc1);
            end
         end
      end
      c = ~c;
      idle(6);
      checks++;
      if (q1.size() != 8 || q1[0] !== 8'h01 || q1[5] !== 8'h06 || q1[6] !== c[7:0] || q1[7] !== c[15:8]) begin
         errors++;
         $display("FAIL len_fwd: got %0d bytes expected 8 with crc %h %h", q1.size(), c[7:0], c[15:8]);
      end
      checks++;
      if (le[1] !== 1'b1 || bc1 !== 3'd4 || le[0] !== 1'b0 || dn1 != 1) begin
         errors++;
         $display("FAIL len_sticky: got le4=%b cnt=%0d le=%b done=%0d expected 1 4 0 1", le[1], bc1, le[0], dn1);
      end
   endtask

   task automatic test_passthru();
      clr();
      send(2, 8'hA5, 1'b1, 1'b0);
      idle(4);
      checks++;
      if (q2.size() != 1 || q2[0] !== 8'hA5 || dn2 != 1) begin
         errors++;
         $display("FAIL pass_byte: got %0d bytes done=%0d expected 1 byte a5 done=1", q2.size(), dn2);
      end
      clr();
      send(2, 8'h00, 1'b1, 1'b1);
      @(negedge clk);
      checks++;
      if (pd[2] !== 1'b1) begin
         errors++;
         $display("FAIL pass_zlp_pulse: got %b expected 1", pd[2]);
      end
      idle(4);
      checks++;
      if (q2.size() != 0 || dn2 != 1) begin
         errors++;
         $display("FAIL pass_zlp: got %0d bytes done=%0d expected 0 and 1", q2.size(), dn2);
      end
   endtask

   initial begin
      test_reset();
      test_check_string();
      test_zero_len();
      test_random_stall();
      test_back_to_back();
      test_reset_mid();
      test_len_err();
      test_passthru();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
